// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and encodings for the two-source round-robin mux arbiter.
// Select and priority use opposite polarities for A, so both are named here.
package mux_arb_pkg;

  typedef enum logic {IDLE, HOLD} arb_state_t;

  localparam logic SEL_A  = 1'b1;
  localparam logic SEL_B  = 1'b0;
  localparam logic PRIO_A = 1'b0;
  localparam logic PRIO_B = 1'b1;

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Bundle of the two source channels, the output channel and the mux control lines.
interface rr_mux_arbiter_if #(
  parameter int WIDTH = 8
);

  // Handshake: a word moves on a rising edge where its valid and ready are both 1;
  // valid/data may change freely while ready is 0, and ready never waits on a later valid.
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             sel;
  logic             prio;

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, sel, prio
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, sel, prio
  );

endinterface

// File: rtl/rr_mux_arbiter_pick2.sv
// Combinational conflict rule: a lone requester wins, a tie goes to the prio side.
module rr_pick2
  import mux_arb_pkg::*;
(
  input  logic i_a_valid,
  input  logic i_b_valid,
  input  logic i_prio,
  output logic o_pick_a,
  output logic o_pick_b
);

  assign o_pick_a = i_a_valid & (~i_b_valid | (i_prio == PRIO_A));
  assign o_pick_b = i_b_valid & (~i_a_valid | (i_prio == PRIO_B));

endmodule

// File: rtl/rr_mux_arbiter.sv
// Two-source round-robin arbiter with a one-word registered output stage.
// Drives the downstream 2:1 mux select and holds the granted word until accepted.
module rr_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit INIT_PRIO = 1'b0
)(
  input  logic                 clk,
  input  logic                 rst_n,
  rr_mux_arbiter_if.slave      bus,
  output arb_state_t           o_dbg_state
);

  arb_state_t       r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_sel;
  logic             r_prio;

  logic w_load_ok;
  logic w_pick_a;
  logic w_pick_b;
  logic w_a_ready;
  logic w_b_ready;

  rr_pick2 u_pick (
    .i_a_valid (bus.a_valid),
    .i_b_valid (bus.b_valid),
    .i_prio    (r_prio),
    .o_pick_a  (w_pick_a),
    .o_pick_b  (w_pick_b)
  );

  // Draining and reloading in the same cycle keeps one word per cycle under out_ready=1.
  assign w_load_ok = (r_state == IDLE) | (r_out_valid & bus.out_ready);
  assign w_a_ready = w_load_ok & w_pick_a;
  assign w_b_ready = w_load_ok & w_pick_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sel       <= SEL_A;
      r_prio      <= INIT_PRIO;
    end else begin
      case (r_state)
        IDLE, HOLD: begin
          if (w_a_ready) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
            r_out_data  <= bus.a_data;
            r_sel       <= SEL_A;
            r_prio      <= PRIO_B;
          end else if (w_b_ready) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
            r_out_data  <= bus.b_data;
            r_sel       <= SEL_B;
            r_prio      <= PRIO_A;
          end else if ((r_state == HOLD) && bus.out_ready) begin
            // Data and select keep their last values so the mux stays quiet.
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a_ready   = w_a_ready;
  assign bus.b_ready   = w_b_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.sel       = r_sel;
  assign bus.prio      = r_prio;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: a fairness model checked every cycle plus hand-computed pins.
module tb_rr_mux_arbiter;
  import mux_arb_pkg::*;

  localparam int W = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  arb_state_t dbg_state;

  int total = 0;
  int bad   = 0;

  rr_mux_arbiter_if #(.WIDTH(W)) bus ();

  rr_mux_arbiter #(.WIDTH(W), .INIT_PRIO(1'b0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_full: a word is waiting downstream; m_turn: whose turn on a tie (0 = A).
  logic         m_full = 1'b0;
  logic [W-1:0] m_word = '0;
  logic         m_last = 1'b1;
  logic         m_turn = 1'b0;
  logic [W-1:0] exp_q[$];

  function automatic logic [1:0] model_grant(input logic av, input logic bv,
                                             input logic full, input logic ordy,
                                             input logic turn);
    if (full && !ordy) return 2'b00;
    if (av && (!bv || turn == 1'b0)) return 2'b10;
    if (bv) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [1:0] g;
    if (!rst_n) begin
      m_full = 1'b0;
      m_word = '0;
      m_last = 1'b1;
      m_turn = 1'b0;
      exp_q.delete();
    end else begin
      g = model_grant(bus.a_valid, bus.b_valid, m_full, bus.out_ready, m_turn);
      if (g == 2'b10) begin
        m_full = 1'b1; m_word = bus.a_data; m_last = 1'b1; m_turn = 1'b1;
        exp_q.push_back(bus.a_data);
      end else if (g == 2'b01) begin
        m_full = 1'b1; m_word = bus.b_data; m_last = 1'b0; m_turn = 1'b0;
        exp_q.push_back(bus.b_data);
      end else if (bus.out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // ---------------- compare process (1 ns before each rising edge) ----------------
  initial begin
    logic [1:0]   g;
    logic [W-1:0] front;
    forever begin
      @(negedge clk);
      #4;
      g = model_grant(bus.a_valid, bus.b_valid, m_full, bus.out_ready, m_turn);
      chk("a_ready", 32'(bus.a_ready), 32'(g[1]));
      chk("b_ready", 32'(bus.b_ready), 32'(g[0]));
      chk("out_valid", 32'(bus.out_valid), 32'(m_full));
      chk("out_data", 32'(bus.out_data), 32'(m_word));
      chk("sel", 32'(bus.sel), 32'(m_last));
      chk("prio", 32'(bus.prio), 32'(m_turn));
      chk("state", 32'(dbg_state == HOLD), 32'(m_full));
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          front = exp_q.pop_front();
          chk("scoreboard_word", 32'(bus.out_data), 32'(front));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic av, input logic [W-1:0] ad,
                       input logic bv, input logic [W-1:0] bd, input logic ordy);
    @(negedge clk);
    bus.a_valid   = av;
    bus.a_data    = ad;
    bus.b_valid   = bv;
    bus.b_data    = bd;
    bus.out_ready = ordy;
  endtask

  task automatic pin_out(input string tag, input logic v, input logic [W-1:0] d,
                         input logic s, input logic p);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, "_data"},  32'(bus.out_data),  32'(d));
    chk({tag, "_sel"},   32'(bus.sel),       32'(s));
    chk({tag, "_prio"},  32'(bus.prio),      32'(p));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [W-1:0] prev;
    bus.a_valid = 1'b0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_data = '0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #4;
    pin_out("reset", 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      #4;
      pin_out("idle", 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // lone B while prio points at A
    drive(1'b0, 8'h00, 1'b1, 8'h77, 1'b1);
    #4 chk("lone_b_ready", 32'(bus.b_ready), 32'd1);
    // single A, reloading in the same cycle the 0x77 drains
    drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
    #4;
    pin_out("lone_b", 1'b1, 8'h77, 1'b0, 1'b0);
    chk("single_a_ready", 32'(bus.a_ready), 32'd1);

    // both valid with prio at B: B wins 0x3C
    drive(1'b1, 8'hC3, 1'b1, 8'h3C, 1'b1);
    #4;
    pin_out("single_a", 1'b1, 8'h5A, 1'b1, 1'b1);
    chk("tie_b_ready", 32'(bus.b_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hC3, 1'b1, 8'h3C, 1'b0);
      #4;
      pin_out("bp_hold", 1'b1, 8'h3C, 1'b0, 1'b0);
      chk("bp_a_ready", 32'(bus.a_ready), 32'd0);
      chk("bp_b_ready", 32'(bus.b_ready), 32'd0);
    end
    drive(1'b1, 8'hC3, 1'b1, 8'h3C, 1'b1);
    #4;
    chk("bp_release_a_ready", 32'(bus.a_ready), 32'd1);
    chk("bp_release_b_ready", 32'(bus.b_ready), 32'd0);
    drive(1'b0, 8'h00, 1'b1, 8'h88, 1'b1);
    #4;
    pin_out("bp_after", 1'b1, 8'hC3, 1'b1, 1'b1);

    // fair alternation starting from prio at A
    prev = 8'h88;
    for (int n = 0; n < 6; n++) begin
      drive(1'b1, 8'(8'hA0 + n), 1'b1, 8'(8'hB0 + n), 1'b1);
      #4;
      chk("alt_a_ready", 32'(bus.a_ready), 32'(n % 2 == 0));
      chk("alt_b_ready", 32'(bus.b_ready), 32'(n % 2 == 1));
      chk("alt_prev_data", 32'(bus.out_data), 32'(prev));
      chk("alt_prev_sel", 32'(bus.sel), 32'(n % 2 == 1));
      prev = (n % 2 == 0) ? 8'(8'hA0 + n) : 8'(8'hB0 + n);
    end

    // reset pulse in the middle of a held word
    drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
    #4;
    pin_out("alt_last", 1'b1, 8'hB5, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #1;
    pin_out("pre_rst", 1'b1, 8'h11, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    pin_out("mid_rst", 1'b0, 8'h00, 1'b1, 1'b0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      #4;
      pin_out("post_rst", 1'b0, 8'h00, 1'b1, 1'b0);
    end

    #10;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
